// File: rtl/cpu_dump_serializer_if.sv
// rtl/cpu_dump_serializer_if.sv - byte stream interface between the dump serializer and its sink
interface cpu_dump_serializer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/cpu_dump_serializer.sv
// rtl/cpu_dump_serializer.sv - frames CPU r1..r3 snapshots into a byte stream, END_BYTE after halt
// Optional: DUMP_CHECKSUM_EN appends an XOR checksum byte to every dump frame.
module cpu_dump_serializer #(
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter logic [7:0] END_BYTE = 8'h5A,
  parameter int         DROP_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  dump_i,
  input  logic                  halt_i,
  input  logic [31:0]           r1_i,
  input  logic [31:0]           r2_i,
  input  logic [31:0]           r3_i,
  cpu_dump_serializer_if.master tx,
  output logic                  busy,
  output logic                  done,
  output logic [DROP_W-1:0]     drop_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, TERM, DONE} state_t;

`ifdef DUMP_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd13;
`else
  localparam logic [3:0] LAST_IDX = 4'd12;
`endif

  state_t      state, state_next;
  logic        dump_q, halt_q;
  logic        pending, halt_seen;
  logic [95:0] sbuf, pend_buf;
  logic [3:0]  idx;
  logic [7:0]  tx_data_q;
  logic        tx_valid;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  wire dump_edge = dump_i & ~dump_q;
  wire halt_edge = halt_i & ~halt_q;
  wire halt_any  = halt_seen | halt_edge;
  wire xfer      = tx_valid & tx.tx_ready;
  wire frame_end = (state == SEND) && xfer && (idx == LAST_IDX);

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dump_edge)      state_next = SEND;
        else if (halt_edge) state_next = TERM;
      end
      // A dump arriving on the last byte restarts the frame directly, so no gap either way.
      SEND: begin
        if (frame_end && !pending && !dump_edge)
          state_next = halt_any ? TERM : IDLE;
      end
      TERM: begin
        if (xfer) state_next = DONE;
      end
      default: state_next = DONE;
    endcase
  end

  always_comb begin
    tx_valid = (state == SEND) || (state == TERM);
    done     = (state == DONE);
    busy     = tx_valid | pending;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dump_q    <= 1'b0;
      halt_q    <= 1'b0;
      pending   <= 1'b0;
      halt_seen <= 1'b0;
      sbuf      <= '0;
      pend_buf  <= '0;
      idx       <= '0;
      tx_data_q <= '0;
      drop_cnt  <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      dump_q <= dump_i;
      halt_q <= halt_i;
      if (halt_edge && state != DONE) halt_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (dump_edge) begin
            sbuf      <= {r1_i, r2_i, r3_i};
            tx_data_q <= HDR_BYTE;
            idx       <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
          end else if (halt_edge) begin
            tx_data_q <= END_BYTE;
          end
        end
        SEND: begin
          if (dump_edge) begin
            if (pending) begin
              if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
            end else if (!frame_end) begin
              pend_buf <= {r1_i, r2_i, r3_i};
              pending  <= 1'b1;
            end
          end
          if (xfer) begin
`ifdef DUMP_CHECKSUM_EN
            csum <= csum ^ tx_data_q;
`endif
            if (frame_end) begin
              if (pending || dump_edge) begin
                sbuf      <= pending ? pend_buf : {r1_i, r2_i, r3_i};
                pending   <= 1'b0;
                tx_data_q <= HDR_BYTE;
                idx       <= '0;
`ifdef DUMP_CHECKSUM_EN
                csum      <= '0;
`endif
              end else if (halt_any) begin
                tx_data_q <= END_BYTE;
              end
            end else begin
              idx <= idx + 4'd1;
`ifdef DUMP_CHECKSUM_EN
              // Byte 12 is r3[7:0]; fold it into the running XOR to form the trailer.
              if (idx == 4'd12) tx_data_q <= csum ^ tx_data_q;
              else              tx_data_q <= sbuf[95:88];
`else
              tx_data_q <= sbuf[95:88];
`endif
              sbuf <= {sbuf[87:0], 8'h00};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_dump_serializer.sv
// tb/tb_cpu_dump_serializer.sv - self-checking bench for cpu_dump_serializer
module tb_cpu_dump_serializer;

`ifdef DUMP_CHECKSUM_EN
  localparam int FRAME_LEN = 14;
`else
  localparam int FRAME_LEN = 13;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dump_i = 1'b0;
  logic        halt_i = 1'b0;
  logic [31:0] r1_i = '0, r2_i = '0, r3_i = '0;
  logic        busy, done;
  logic [7:0]  drop_cnt;

  cpu_dump_serializer_if tif ();

  cpu_dump_serializer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .dump_i   (dump_i),
    .halt_i   (halt_i),
    .r1_i     (r1_i),
    .r2_i     (r2_i),
    .r3_i     (r3_i),
    .tx       (tif.master),
    .busy     (busy),
    .done     (done),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r1, r2, r3;
    bit          rnd_ready;
    int          exp_bytes;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] exp_q[$];
  int         xfer_cyc[$];
  int         checks = 0, errors = 0;
  int         cyc = 0, xfer_cnt = 0;
  bit         rnd_mode = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [95:0] w;
    logic [7:0]  x;
    w = {a, b, c};
    x = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(w[95 - 8*i -: 8]);
      x = x ^ w[95 - 8*i -: 8];
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Ready only changes at the falling edge, so what is sampled here decides the next rising edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    tif.tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'b0, tif.tx_valid}, 32'd1);
        chk("stall_data", {24'b0, tif.tx_data}, {24'b0, prev_data});
      end
      if (tif.tx_valid && tif.tx_ready) begin
        xfer_cnt++;
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'b0, tif.tx_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("byte", {24'b0, tif.tx_data}, {24'b0, e});
        end
      end
      prev_stall = tif.tx_valid && !tif.tx_ready;
      prev_data  = tif.tx_data;
    end
  endtask

  task automatic pulse(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input bit push);
    r1_i = a; r2_i = b; r3_i = c;
    dump_i = 1'b1;
    if (push) push_frame(a, b, c);
    tick();
    dump_i = 1'b0;
    tick();
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      tick();
      n++;
    end
    chk("drain_timeout", {31'b0, n >= max}, 32'd0);
  endtask

  initial begin
    int n0;
    vecs[0] = '{32'h0000_0001, 32'h0000_0048, 32'hDEAD_BEEF, 1'b0, FRAME_LEN, 8'd0};
    vecs[1] = '{32'h0000_0001, 32'h0000_0048, 32'hDEAD_BEEF, 1'b1, FRAME_LEN, 8'd0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001, 1'b1, FRAME_LEN, 8'd0};
    vecs[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1'b0, FRAME_LEN, 8'd0};

    tif.tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", {31'b0, tif.tx_valid}, 32'd0);
    chk("rst_data", {24'b0, tif.tx_data}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_drop", {24'b0, drop_cnt}, 32'd0);
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      rnd_mode = vecs[i].rnd_ready;
      n0 = xfer_cnt;
      pulse(vecs[i].r1, vecs[i].r2, vecs[i].r3, 1'b1);
      drain(400);
      rnd_mode = 0;
      repeat (2) tick();
      chk("vec_bytes", xfer_cnt - n0, vecs[i].exp_bytes);
      chk("vec_drop", {24'b0, drop_cnt}, {24'b0, vecs[i].exp_drop});
      chk("vec_idle_valid", {31'b0, tif.tx_valid}, 32'd0);
    end

    // Three pulses inside one frame: second queued, third dropped, frames back-to-back.
    n0 = xfer_cyc.size();
    pulse(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b1);
    pulse(32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 1'b1);
    pulse(32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 1'b0);
    drain(200);
    chk("b2b_count", xfer_cyc.size() - n0, 2 * FRAME_LEN);
    if (xfer_cyc.size() >= n0 + 2 * FRAME_LEN)
      chk("b2b_no_gap", xfer_cyc[n0 + 2*FRAME_LEN - 1] - xfer_cyc[n0], 2 * FRAME_LEN - 1);
    chk("b2b_drop", {24'b0, drop_cnt}, 32'd1);

    // Reset mid-stream clears everything at once.
    pulse(32'hCAFE_F00D, 32'h0BAD_BEEF, 32'h0000_0000, 1'b1);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, tif.tx_valid}, 32'd0);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_done", {31'b0, done}, 32'd0);
    chk("mrst_drop", {24'b0, drop_cnt}, 32'd0);
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    pulse(32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 1'b1);
    drain(200);

    // A held dump level produces a single frame.
    n0 = xfer_cnt;
    r1_i = 32'h7; r2_i = 32'h8; r3_i = 32'h9;
    dump_i = 1'b1;
    push_frame(32'h7, 32'h8, 32'h9);
    repeat (20) tick();
    dump_i = 1'b0;
    drain(200);
    repeat (5) tick();
    chk("held_bytes", xfer_cnt - n0, FRAME_LEN);

    // Halt mid-frame: frame completes, then END, then silence.
    pulse(32'h0000_00AA, 32'h0000_00BB, 32'h0000_00CC, 1'b1);
    tick();
    halt_i = 1'b1;
    exp_q.push_back(8'h5A);
    tick();
    chk("halt_busy", {31'b0, busy}, 32'd1);
    drain(200);
    chk("halt_done", {31'b0, done}, 32'd1);
    chk("halt_valid", {31'b0, tif.tx_valid}, 32'd0);
    n0 = xfer_cnt;
    pulse(32'h1, 32'h2, 32'h3, 1'b0);
    pulse(32'h4, 32'h5, 32'h6, 1'b0);
    repeat (20) tick();
    chk("post_halt_xfers", xfer_cnt - n0, 0);
    chk("post_halt_valid", {31'b0, tif.tx_valid}, 32'd0);
    chk("post_halt_done", {31'b0, done}, 32'd1);
    chk("post_halt_busy", {31'b0, busy}, 32'd0);
    chk("post_halt_drop", {24'b0, drop_cnt}, 32'd0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
